// File: rtl/rat_ckpt_multi_pkg.sv
// rat_ckpt_multi_pkg: shared types and sizes for the checkpointed register alias table
package rat_ckpt_multi_pkg;
   localparam int WIDTH            = 2;
   localparam int CDB_PORTS        = 2;
   localparam int PREG_IDX_WIDTH   = 6;
   localparam int NUM_PREGS        = 2 ** PREG_IDX_WIDTH;
   localparam int NUM_CKPT_DEFAULT = 4;
   localparam int NUM_CKPT         = NUM_CKPT_DEFAULT;
   localparam int CKPT_IDX_WIDTH   = $clog2(NUM_CKPT);

   typedef logic [PREG_IDX_WIDTH-1:0] free_list_entry_t;
   typedef logic [CKPT_IDX_WIDTH-1:0] ckpt_id_t;
   typedef logic [CKPT_IDX_WIDTH:0]   ckpt_cnt_t;
   typedef free_list_entry_t [31:0]   rat_map_t;

   typedef struct packed {
      logic             cdb_valid;
      free_list_entry_t preg_index;
   } cdb_t;

   function automatic rat_map_t identity_map();
      rat_map_t m;
      for (int i = 0; i < 32; i++) m[i] = free_list_entry_t'(i);
      return m;
   endfunction
endpackage

// File: rtl/rat_ckpt_multi_if.sv
// rat_ckpt_multi_if: rename, completion and checkpoint-control bundle between dispatch and the RAT
interface rat_ckpt_multi_if;
   import rat_ckpt_multi_pkg::*;
   logic [WIDTH-1:0]           ren_valid;
   logic [WIDTH-1:0][4:0]      ren_rd;
   free_list_entry_t [WIDTH-1:0] ren_pd;
   logic [WIDTH-1:0][4:0]      ren_rs1;
   logic [WIDTH-1:0][4:0]      ren_rs2;
   free_list_entry_t [WIDTH-1:0] ren_ps1;
   free_list_entry_t [WIDTH-1:0] ren_ps2;
   logic [WIDTH-1:0]           ren_ps1_rdy;
   logic [WIDTH-1:0]           ren_ps2_rdy;
   cdb_t [CDB_PORTS-1:0]       cdb;
   logic                       ckpt_alloc;
   logic                       ckpt_avail;
   ckpt_id_t                   ckpt_alloc_id;
   logic                       ckpt_release;
   logic                       ckpt_restore;
   ckpt_id_t                   ckpt_restore_id;
   logic                       branch_flush;
   rat_map_t                   areg_array_rrf;

   modport master (
      output ren_valid, ren_rd, ren_pd, ren_rs1, ren_rs2, cdb, ckpt_alloc, ckpt_release,
             ckpt_restore, ckpt_restore_id, branch_flush, areg_array_rrf,
      input  ren_ps1, ren_ps2, ren_ps1_rdy, ren_ps2_rdy, ckpt_avail, ckpt_alloc_id
   );

   modport slave (
      input  ren_valid, ren_rd, ren_pd, ren_rs1, ren_rs2, cdb, ckpt_alloc, ckpt_release,
             ckpt_restore, ckpt_restore_id, branch_flush, areg_array_rrf,
      output ren_ps1, ren_ps2, ren_ps1_rdy, ren_ps2_rdy, ckpt_avail, ckpt_alloc_id
   );
endinterface

// File: rtl/rat_ckpt_multi_ckpt_store.sv
// rat_ckpt_store: circular buffer of map snapshots with alloc/release/restore pointer logic
module rat_ckpt_store
   import rat_ckpt_multi_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     flush_i,
   input  logic     alloc_i,
   input  logic     release_i,
   input  logic     restore_i,
   input  ckpt_id_t restore_id_i,
   input  rat_map_t snap_i,
   output logic     avail_o,
   output ckpt_id_t alloc_id_o,
   output rat_map_t restore_map_o
);
   rat_map_t  slot_q [NUM_CKPT];
   ckpt_id_t  head_q, head_d, tail_q, tail_d, head_rel;
   ckpt_cnt_t count_q, count_d;
   logic      rel, alc, wr;

   // a release frees the head first, so a full queue can still accept an alloc in the same cycle
   always_comb begin
      rel      = release_i && count_q != '0;
      head_rel = head_q + ckpt_id_t'(rel);
      alc      = alloc_i && (count_q != ckpt_cnt_t'(NUM_CKPT) || rel);
      wr       = !flush_i && !restore_i && alc;
      head_d   = flush_i ? '0 : head_rel;
      tail_d   = flush_i ? '0 : restore_i ? restore_id_i : tail_q + ckpt_id_t'(alc);
      count_d  = flush_i ? '0 :
                 restore_i ? ckpt_cnt_t'(ckpt_id_t'(restore_id_i - head_rel)) :
                 count_q - ckpt_cnt_t'(rel) + ckpt_cnt_t'(alc);
   end

   // queue pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // snapshot storage needs no reset: a slot is only read after it has been written
   always_ff @(posedge clk) begin
      if (wr) slot_q[tail_q] <= snap_i;
   end

   assign avail_o       = count_q != ckpt_cnt_t'(NUM_CKPT);
   assign alloc_id_o    = tail_q;
   assign restore_map_o = slot_q[restore_id_i];
endmodule

// File: rtl/rat_ckpt_multi.sv
// rat_ckpt_multi: multi-lane register alias table with per-preg readiness and branch checkpoints
module rat_ckpt_multi
   import rat_ckpt_multi_pkg::*;
(
   input logic             clk,
   input logic             rst,
   rat_ckpt_multi_if.slave rat_io
);
   rat_map_t                     map_q, map_d, map_ren, restore_map;
   logic [NUM_PREGS-1:0]         rdy_q, rdy_d, rdy_ren, cdb_hit;
   free_list_entry_t [WIDTH-1:0] ps1, ps2;
   logic [WIDTH-1:0]             rdy1, rdy2;
   logic                         avail;
   ckpt_id_t                     alloc_id;

   // returns {ready, preg}; a younger lane's earlier sibling writing src overrides the map
   function automatic logic [PREG_IDX_WIDTH:0] lookup(input int j, input logic [4:0] src);
      free_list_entry_t ps;
      logic             rdy;
      ps  = map_q[src];
      rdy = rdy_q[ps] | cdb_hit[ps];
      for (int i = 0; i < WIDTH; i++)
         if (i < j && rat_io.ren_valid[i] && rat_io.ren_rd[i] == src) begin
            ps  = rat_io.ren_pd[i];
            rdy = 1'b0;
         end
      if (src == 5'd0) begin
         ps  = '0;
         rdy = 1'b1;
      end
      return {rdy, ps};
   endfunction

   // one-hot of pregs completing on any CDB port this cycle
   always_comb begin
      cdb_hit = '0;
      for (int p = 0; p < CDB_PORTS; p++)
         if (rat_io.cdb[p].cdb_valid) cdb_hit[rat_io.cdb[p].preg_index] = 1'b1;
   end

   // same-cycle source renaming for every lane
   always_comb begin
      ps1  = '0;
      ps2  = '0;
      rdy1 = '0;
      rdy2 = '0;
      for (int j = 0; j < WIDTH; j++) begin
         {rdy1[j], ps1[j]} = lookup(j, rat_io.ren_rs1[j]);
         {rdy2[j], ps2[j]} = lookup(j, rat_io.ren_rs2[j]);
      end
   end

   // post-rename map (also the snapshot source); rename clears apply after CDB sets
   always_comb begin
      map_ren = map_q;
      rdy_ren = rdy_q | cdb_hit;
      for (int i = 0; i < WIDTH; i++)
         if (rat_io.ren_valid[i] && rat_io.ren_rd[i] != 5'd0 && rat_io.ren_pd[i] != '0) begin
            map_ren[rat_io.ren_rd[i]] = rat_io.ren_pd[i];
            rdy_ren[rat_io.ren_pd[i]] = 1'b0;
         end
      map_d = rat_io.branch_flush ? rat_io.areg_array_rrf : rat_io.ckpt_restore ? restore_map : map_ren;
      rdy_d = rat_io.branch_flush ? '1 : rat_io.ckpt_restore ? rdy_q | cdb_hit : rdy_ren;
   end

   rat_ckpt_store u_store (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (rat_io.branch_flush),
      .alloc_i      (rat_io.ckpt_alloc),
      .release_i    (rat_io.ckpt_release),
      .restore_i    (rat_io.ckpt_restore),
      .restore_id_i (rat_io.ckpt_restore_id),
      .snap_i       (map_ren),
      .avail_o      (avail),
      .alloc_id_o   (alloc_id),
      .restore_map_o(restore_map)
   );

   // architectural map and readiness state
   always_ff @(posedge clk) begin
      if (rst) begin
         map_q <= identity_map();
         rdy_q <= '1;
      end else begin
         map_q <= map_d;
         rdy_q <= rdy_d;
      end
   end

   assign rat_io.ren_ps1       = ps1;
   assign rat_io.ren_ps2       = ps2;
   assign rat_io.ren_ps1_rdy   = rdy1;
   assign rat_io.ren_ps2_rdy   = rdy2;
   assign rat_io.ckpt_avail    = avail;
   assign rat_io.ckpt_alloc_id = alloc_id;
endmodule
